addsub_pipe: RTL and testbench
==============================

// Module: addsub_pipe
// PURPOSE
//  Pipelined, parametrised add/subtract unit; run-time mode select replaces the fixed-function subtract.
//  Operands are split into NUM_STAGES slices; each stage adds one slice and registers its carry,
//  so clock rate is set by SLICE_W rather than BUS_WIDTH.
//  Valid/ready handshake on both sides with full backpressure; throughput 1 op/cycle.
//  Outputs include carry, signed overflow and zero flags for ALU/datapath consumers.
// PARAMETERS
//  BUS_WIDTH   8  operand/result width in bits
//  NUM_STAGES  2  pipeline depth = slice count; BUS_WIDTH % NUM_STAGES must be 0 (elaboration error otherwise)
// PORTS
//  i_clk       in   1          clock, all state on rising edge
//  i_rst       in   1          synchronous reset, active-high
//  i_valid     in   1          input operands valid
//  o_ready     out  1          unit can accept an op this cycle
//  i_a         in   BUS_WIDTH  operand A
//  i_b         in   BUS_WIDTH  operand B
//  i_sub       in   1          0: A+B, 1: A-B (A + ~B + 1)
//  o_valid     out  1          result valid
//  i_ready     in   1          downstream accepts result
//  o_c         out  BUS_WIDTH  result, modulo 2^BUS_WIDTH
//  o_carry     out  1          raw carry out of MSB (sub: 1 = no borrow, A>=B unsigned)
//  o_overflow  out  1          two's-complement signed overflow
//  o_zero      out  1          o_c == 0
// BEHAVIOUR
//  - SLICE_W = BUS_WIDTH/NUM_STAGES. Slice k = bits [k*SLICE_W +: SLICE_W].
//  - Global advance en = !o_valid | i_ready; o_ready = en (combinational). Accept = i_valid & o_ready.
//  - When en=0 every pipeline register holds (stall entire pipe); when en=1 all shift one stage.
//  - Stage 0 captures accepted op: slice0 = a0 + (b0 ^ {SLICE_W{sub}}) + sub, carry registered; upper
//    slices of A and ~B (if sub) registered unchanged. Stage k adds slice k with carry from stage k-1;
//    lower result slices are delayed alongside so result bits align at output.
//  - Latency exactly NUM_STAGES cycles from accept to o_valid (no stalls); NUM_STAGES=1 -> single registered stage.
//  - Valid bit travels per stage; bubbles (i_valid=0 with en=1) propagate as invalid slots, no data corruption.
//  - o_overflow = (a_msb == b'_msb) & (c_msb != a_msb), b' = B after optional inversion.
//  - o_c/flags are registered, stable while o_valid & !i_ready; undefined content irrelevant when !o_valid.
//  - Ordering strictly in-order; no op lost or duplicated under any i_valid/i_ready pattern.
//  - Reset: all valid bits 0, o_valid=0, o_c=0, o_carry=0, o_overflow=0, o_zero=0; o_ready=1 the cycle after
//    reset deasserts. Reset mid-stream drops every in-flight op; i_valid during reset is ignored.
//  - Simultaneous accept and output handshake in same cycle is normal streaming, no bubble inserted.
// STRUCTURE
//  - Shared include: mode defines ADDSUB_ADD=1'b0, ADDSUB_SUB=1'b1; used by any ALU decoder.
//  - One sub-module: addsub_slice (SLICE_W-bit adder, inputs a, b, cin; outputs sum, cout, combinational),
//    instantiated NUM_STAGES times in a generate loop; top holds pipeline/skew registers and valid chain.
// TESTING  (BUS_WIDTH=8, NUM_STAGES=2 unless stated)
//  1. add 0x0F+0x01 -> o_c=0x10, carry 0, ovf 0, o_valid exactly 2 cycles after accept (inter-slice carry).
//  2. add 0x7F+0x01 -> 0x80, carry 0, ovf 1; add 0xFF+0x01 -> 0x00, carry 1, ovf 0, zero 1.
//  3. sub 0x00-0x01 -> 0xFF, carry 0, ovf 0; sub 0x80-0x01 -> 0x7F, carry 1, ovf 1; sub 0x55-0x55 -> 0x00, zero 1.
//  4. 32 random back-to-back ops, i_ready random 50%: results match model in order; o_ready==0 iff o_valid&!i_ready.
//  5. i_rst high 1 cycle with 2 ops in flight -> o_valid 0 next cycle, neither op ever emitted; next op correct.
//  6. Repeat 1-4 with NUM_STAGES=1 (latency 1) and BUS_WIDTH=32, NUM_STAGES=4 (0xFFFFFFFF+1 -> 0, carry 1).

Source files
------------

// File: rtl/addsub_pipe_pkg.sv
// rtl/addsub_pipe_pkg.sv - shared add/sub mode encodings and flag helper
package addsub_pipe_pkg;

    localparam logic ADDSUB_ADD = 1'b0;
    localparam logic ADDSUB_SUB = 1'b1;

    // Two's-complement overflow: operands agree in sign, result disagrees.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic c_msb);
        return (a_msb == b_msb) && (c_msb != a_msb);
    endfunction

endpackage

// File: rtl/addsub_slice.sv
// rtl/addsub_slice.sv - combinational SLICE_W-bit adder with carry in/out
module addsub_slice
    import addsub_pipe_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    output logic [SLICE_W-1:0] o_sum,
    output logic               o_cout
);

    logic [SLICE_W:0] w_full;

    assign w_full          = {1'b0, i_a} + {1'b0, i_b} + {{SLICE_W{1'b0}}, i_cin};
    assign {o_cout, o_sum} = w_full;

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - sliced, pipelined add/subtract unit with valid/ready and ALU flags
module addsub_pipe
    import addsub_pipe_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [BUS_WIDTH-1:0] i_a,
    input  logic [BUS_WIDTH-1:0] i_b,
    input  logic                 i_sub,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [BUS_WIDTH-1:0] o_c,
    output logic                 o_carry,
    output logic                 o_overflow,
    output logic                 o_zero
);

    localparam int SW   = BUS_WIDTH / NUM_STAGES;
    localparam int MSB  = BUS_WIDTH - 1;
    localparam int LAST = NUM_STAGES - 1;

    if (BUS_WIDTH % NUM_STAGES != 0) begin : g_bad_cfg
        $error("addsub_pipe: BUS_WIDTH must be a multiple of NUM_STAGES");
    end

    logic                 w_en;
    logic                 w_sub;

    // Stage k holds operands, partial result and carry after slice k has been added.
    logic [BUS_WIDTH-1:0] r_a  [NUM_STAGES];
    logic [BUS_WIDTH-1:0] r_b  [NUM_STAGES];
    logic [BUS_WIDTH-1:0] r_s  [NUM_STAGES];
    logic                 r_cy [NUM_STAGES];
    logic                 r_v  [NUM_STAGES];
    logic                 r_ovf;
    logic                 r_zero;

    logic [BUS_WIDTH-1:0] w_a_in    [NUM_STAGES];
    logic [BUS_WIDTH-1:0] w_b_in    [NUM_STAGES];
    logic [BUS_WIDTH-1:0] w_s_in    [NUM_STAGES];
    logic [BUS_WIDTH-1:0] w_s_nxt   [NUM_STAGES];
    logic [BUS_WIDTH-1:0] w_sum_ext [NUM_STAGES];
    logic [SW-1:0]        w_sum     [NUM_STAGES];
    logic                 w_cin     [NUM_STAGES];
    logic                 w_cout    [NUM_STAGES];
    logic                 w_v_in    [NUM_STAGES];

    assign w_sub   = (i_sub == ADDSUB_SUB);
    assign w_en    = !r_v[LAST] || i_ready;
    assign o_ready = w_en;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            // Subtract folds into add: invert B here, the +1 rides in as carry-in.
            assign w_a_in[k] = i_a;
            assign w_b_in[k] = i_b ^ {BUS_WIDTH{w_sub}};
            assign w_s_in[k] = '0;
            assign w_cin[k]  = w_sub;
            assign w_v_in[k] = i_valid && w_en;
        end else begin : g_next
            assign w_a_in[k] = r_a[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_s_in[k] = r_s[k-1];
            assign w_cin[k]  = r_cy[k-1];
            assign w_v_in[k] = r_v[k-1];
        end

        addsub_slice #(
            .SLICE_W (SW)
        ) u_slice (
            .i_a    (w_a_in[k][k*SW +: SW]),
            .i_b    (w_b_in[k][k*SW +: SW]),
            .i_cin  (w_cin[k]),
            .o_sum  (w_sum[k]),
            .o_cout (w_cout[k])
        );

        assign w_sum_ext[k] = BUS_WIDTH'(w_sum[k]);
        assign w_s_nxt[k]   = w_s_in[k] | (w_sum_ext[k] << (k * SW));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_a[k]  <= '0;
                r_b[k]  <= '0;
                r_s[k]  <= '0;
                r_cy[k] <= 1'b0;
                r_v[k]  <= 1'b0;
            end
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                r_a[k]  <= w_a_in[k];
                r_b[k]  <= w_b_in[k];
                r_s[k]  <= w_s_nxt[k];
                r_cy[k] <= w_cout[k];
                r_v[k]  <= w_v_in[k];
            end
            r_ovf  <= signed_ovf(w_a_in[LAST][MSB], w_b_in[LAST][MSB], w_s_nxt[LAST][MSB]);
            r_zero <= (w_s_nxt[LAST] == '0);
        end
    end

    assign o_valid    = r_v[LAST];
    assign o_c        = r_s[LAST];
    assign o_carry    = r_cy[LAST];
    assign o_overflow = r_ovf;
    assign o_zero     = r_zero;

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - scoreboard bench over three widths/depths of addsub_pipe
module tb_addsub_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc      = 0;
    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        sub;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        cy;
        logic        ov;
        logic        z;
    } vec_t;

    function automatic vec_t get_vec(input int w, input int idx);
        vec_t v;
        v = '0;
        if (w == 8) begin
            case (idx)
                0: v = '{1'b0, 32'h0F, 32'h01, 32'h10, 1'b0, 1'b0, 1'b0};
                1: v = '{1'b0, 32'h7F, 32'h01, 32'h80, 1'b0, 1'b1, 1'b0};
                2: v = '{1'b0, 32'hFF, 32'h01, 32'h00, 1'b1, 1'b0, 1'b1};
                3: v = '{1'b1, 32'h00, 32'h01, 32'hFF, 1'b0, 1'b0, 1'b0};
                4: v = '{1'b1, 32'h80, 32'h01, 32'h7F, 1'b1, 1'b1, 1'b0};
                default: v = '{1'b1, 32'h55, 32'h55, 32'h00, 1'b1, 1'b0, 1'b1};
            endcase
        end else begin
            case (idx)
                0: v = '{1'b0, 32'hFFFFFFFF, 32'h1, 32'h00000000, 1'b1, 1'b0, 1'b1};
                1: v = '{1'b0, 32'h0000FFFF, 32'h1, 32'h00010000, 1'b0, 1'b0, 1'b0};
                2: v = '{1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0};
                3: v = '{1'b1, 32'h00000000, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
                4: v = '{1'b1, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
                default: v = '{1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b1};
            endcase
        end
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
        localparam int BW = (gi == 2) ? 32 : 8;
        localparam int NS = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);

        logic          rst = 1'b1;
        logic          iv  = 1'b0;
        logic          sub = 1'b0;
        logic          ir  = 1'b1;
        logic [BW-1:0] a   = '0;
        logic [BW-1:0] b   = '0;
        logic          ordy, ov, cy, ovf, zr;
        logic [BW-1:0] c;
        logic          lat_mode = 1'b1;
        logic          rnd_ir   = 1'b0;
        logic [BW+2:0] q_res[$];
        int            q_lat[$];

        addsub_pipe #(
            .BUS_WIDTH  (BW),
            .NUM_STAGES (NS)
        ) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_valid    (iv),
            .o_ready    (ordy),
            .i_a        (a),
            .i_b        (b),
            .i_sub      (sub),
            .o_valid    (ov),
            .i_ready    (ir),
            .o_c        (c),
            .o_carry    (cy),
            .o_overflow (ovf),
            .o_zero     (zr)
        );

        function automatic logic [BW+2:0] model(input logic [BW-1:0] fa, input logic [BW-1:0] fb,
                                                input logic fs);
            logic [BW-1:0] bx;
            logic [BW:0]   full;
            bx   = fs ? ~fb : fb;
            full = {1'b0, fa} + {1'b0, bx} + {{BW{1'b0}}, fs};
            return {full[BW-1:0], full[BW],
                    (fa[BW-1] == bx[BW-1]) && (full[BW-1] != fa[BW-1]),
                    full[BW-1:0] == '0};
        endfunction

        function automatic logic [BW+2:0] from_vec(input vec_t v);
            return {v.c[BW-1:0], v.cy, v.ov, v.z};
        endfunction

        // Entered and left at posedge+1; i_valid stays high on return for back-to-back issue.
        task automatic send(input logic [BW-1:0] ta, input logic [BW-1:0] tb_, input logic ts,
                            input logic [BW+2:0] e_res);
            bit acc = 0;
            a   = ta;
            b   = tb_;
            sub = ts;
            iv  = 1'b1;
            for (int t = 0; t < 200 && !acc; t++) begin
                @(negedge clk);
                if (ordy) begin
                    acc = 1;
                    q_res.push_back(e_res);
                    q_lat.push_back(lat_mode ? cyc + NS : -1);
                end
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                n_cmp++;
                n_err++;
                $display("FAIL cfg%0d accept timeout: o_ready stayed 0, required 1", gi);
            end
        endtask

        task automatic drain();
            for (int t = 0; t < 500 && q_res.size() != 0; t++) @(posedge clk);
            #1;
            check($sformatf("cfg%0d drain pending", gi), 64'(q_res.size()), 0);
        endtask

        always @(posedge clk) begin
            if (rnd_ir) begin
                #1 ir = 1'($urandom_range(0, 1));
            end
        end

        always @(negedge clk) begin
            logic [BW+2:0] e;
            int            l;
            if (!rst) begin
                check($sformatf("cfg%0d o_ready", gi), 64'(ordy), 64'(!(ov && !ir)));
                if (ov && ir) begin
                    if (q_res.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL cfg%0d unexpected output: got o_c=%0h, required none", gi, c);
                    end else begin
                        e = q_res.pop_front();
                        l = q_lat.pop_front();
                        check($sformatf("cfg%0d o_c", gi), 64'(c), 64'(e[BW+2:3]));
                        check($sformatf("cfg%0d o_carry", gi), 64'(cy), 64'(e[2]));
                        check($sformatf("cfg%0d o_overflow", gi), 64'(ovf), 64'(e[1]));
                        check($sformatf("cfg%0d o_zero", gi), 64'(zr), 64'(e[0]));
                        if (l >= 0) check($sformatf("cfg%0d latency", gi), 64'(cyc), 64'(l));
                    end
                end
            end
        end

        initial begin
            logic [BW-1:0] ra, rb;
            logic          rs;
            vec_t          v;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check($sformatf("cfg%0d reset o_valid", gi), 64'(ov), 0);
            check($sformatf("cfg%0d reset o_c", gi), 64'(c), 0);
            check($sformatf("cfg%0d reset flags", gi), 64'({cy, ovf, zr}), 0);
            check($sformatf("cfg%0d reset o_ready", gi), 64'(ordy), 1);
            @(posedge clk);
            #1;

            for (int i = 0; i < 6; i++) begin
                v = get_vec(BW, i);
                send(v.a[BW-1:0], v.b[BW-1:0], v.sub, from_vec(v));
                iv = 1'b0;
                repeat (NS + 2) @(posedge clk);
                #1;
            end

            lat_mode = 1'b0;
            rnd_ir   = 1'b1;
            for (int i = 0; i < 32; i++) begin
                ra = BW'($urandom);
                rb = BW'($urandom);
                rs = 1'($urandom_range(0, 1));
                send(ra, rb, rs, model(ra, rb, rs));
            end
            iv = 1'b0;
            drain();
            rnd_ir = 1'b0;
            @(posedge clk);
            #1 ir = 1'b1;

            for (int i = 0; i < 2; i++) begin
                ra = BW'($urandom);
                rb = BW'($urandom);
                send(ra, rb, 1'b0, model(ra, rb, 1'b0));
            end
            rst = 1'b1;
            ir  = 1'b0;
            a   = '1;
            b   = '1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            iv  = 1'b0;
            ir  = 1'b1;
            q_res.delete();
            q_lat.delete();
            @(negedge clk);
            check($sformatf("cfg%0d post-reset o_valid", gi), 64'(ov), 0);
            check($sformatf("cfg%0d post-reset o_c", gi), 64'(c), 0);
            repeat (NS + 3) @(posedge clk);
            #1;

            lat_mode = 1'b1;
            v = get_vec(BW, 0);
            send(v.a[BW-1:0], v.b[BW-1:0], v.sub, from_vec(v));
            iv = 1'b0;
            drain();
            done_cnt++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && done_cnt < 3; t++) @(posedge clk);
        if (done_cnt < 3) begin
            n_cmp++;
            n_err++;
            $display("FAIL run timeout: %0d configs done, required 3", done_cnt);
        end
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
